// File: rtl/f_round_param.sv
// f_round_param: one substitution round over BYTES byte lanes with a runtime-loaded
// S-box. Encrypt is XOR-key, substitute, rotate left by ROT bytes. Decrypt is
// un-rotate, inverse substitute, XOR-key. The result appears two edges after the
// block is accepted.
module f_round_param #(
   parameter int BYTES = 16,
   parameter int ROT   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           sbox_out,
   input  logic                 sbox_valid,
   input  logic                 tvalid,
   input  logic                 dec,
   input  logic [8*BYTES-1:0]   state_in,
   input  logic [8*BYTES-1:0]   round_key,
   output logic [8*BYTES-1:0]   state_out,
   output logic                 valid,
   output logic                 sbox_ready,
   output logic                 sbox_bad,
   output logic                 drop
);

   localparam int W = 8 * BYTES;

   logic [7:0]   sbox_q [256];
   logic [7:0]   sinv_q [256];
   logic [255:0] seen_q, seen_d;
   logic [7:0]   idx_q, idx_d, wr_idx;
   logic         ready_q, ready_d, bad_q, bad_d, drop_q, drop_d;
   logic         accept;

   logic         s1_valid_q, s1_dec_q;
   logic [W-1:0] s1_data_q, s1_key_q, s1_data_d;
   logic         s2_valid_q, s2_dec_q;
   logic [W-1:0] s2_data_q, s2_key_q, s2_data_d;
   logic         valid_q;
   logic [W-1:0] out_q, out_d;

   // Load bookkeeping: a write while the table is complete restarts the load at index 0.
   always_comb begin
      wr_idx  = ready_q ? 8'd0 : idx_q;
      seen_d  = seen_q;
      idx_d   = idx_q;
      ready_d = ready_q;
      bad_d   = bad_q;
      if (sbox_valid) begin
         if (ready_q) begin
            seen_d = '0;
            bad_d  = 1'b0;
         end else if (seen_q[sbox_out]) begin
            bad_d  = 1'b1;
         end
         seen_d[sbox_out] = 1'b1;
         idx_d   = wr_idx + 8'd1;
         ready_d = (wr_idx == 8'hFF);
      end
   end

   assign accept = tvalid & ready_q;
   assign drop_d = tvalid & ~ready_q;

   // Table storage has no reset; contents survive a reset and are simply reloaded.
   always_ff @(posedge clk) begin
      if (sbox_valid) begin
         sbox_q[wr_idx]   <= sbox_out;
         sinv_q[sbox_out] <= wr_idx;
      end
   end

   // Stage-1 preparation: encrypt pre-XORs the key, decrypt undoes the rotation.
   always_comb begin
      s1_data_d = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (dec) s1_data_d[8*i +: 8] = state_in[8*((i+ROT)%BYTES) +: 8];
         else     s1_data_d[8*i +: 8] = state_in[8*i +: 8] ^ round_key[8*i +: 8];
      end
   end

   // Stage-2 table lookup, forward or inverse depending on the block's own mode.
   always_comb begin
      s2_data_d = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (s1_dec_q) s2_data_d[8*i +: 8] = sinv_q[s1_data_q[8*i +: 8]];
         else          s2_data_d[8*i +: 8] = sbox_q[s1_data_q[8*i +: 8]];
      end
   end

   // Output finishing: encrypt rotates left, decrypt applies the key after the lookup.
   always_comb begin
      out_d = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (s2_dec_q) out_d[8*i +: 8] = s2_data_q[8*i +: 8] ^ s2_key_q[8*i +: 8];
         else          out_d[8*((i+ROT)%BYTES) +: 8] = s2_data_q[8*i +: 8];
      end
   end

   // Control registers and the three pipeline stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seen_q     <= '0;
         idx_q      <= '0;
         ready_q    <= 1'b0;
         bad_q      <= 1'b0;
         drop_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_dec_q   <= 1'b0;
         s1_data_q  <= '0;
         s1_key_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_dec_q   <= 1'b0;
         s2_data_q  <= '0;
         s2_key_q   <= '0;
         valid_q    <= 1'b0;
         out_q      <= '0;
      end else begin
         seen_q     <= seen_d;
         idx_q      <= idx_d;
         ready_q    <= ready_d;
         bad_q      <= bad_d;
         drop_q     <= drop_d;
         s1_valid_q <= accept;
         s1_dec_q   <= dec;
         s1_data_q  <= s1_data_d;
         s1_key_q   <= round_key;
         s2_valid_q <= s1_valid_q;
         s2_dec_q   <= s1_dec_q;
         s2_data_q  <= s2_data_d;
         s2_key_q   <= s1_key_q;
         valid_q    <= s2_valid_q;
         if (s2_valid_q) out_q <= out_d;
      end
   end

   assign state_out  = out_q;
   assign valid      = valid_q;
   assign sbox_ready = ready_q;
   assign sbox_bad   = bad_q;
   assign drop       = drop_q;

endmodule

// File: tb/tb_f_round_param.sv
// Bench for f_round_param: two instances (ROT=0 and ROT=5) share the stimulus and
// are checked against a direct arithmetic model of the round.
module tb_f_round_param;
   localparam int W    = 128;
   localparam int ROTB = 5;
   localparam logic [W-1:0] KVEC = 128'h0F0E0D0C0B0A09080706050403020100;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   sbox_out;
   logic         sbox_valid, tvalid, dec;
   logic [W-1:0] state_in, round_key;
   logic [W-1:0] so_a, so_b;
   logic         v_a, v_b, rdy_a, rdy_b, bad_a, bad_b, drp_a, drp_b;

   int errors = 0;
   int checks = 0;
   logic [7:0]   mS [256];
   logic [7:0]   mSi[256];
   int           m_idx = 0;
   logic [W-1:0] last_a, last_b;

   always #5 clk = ~clk;

   f_round_param #(.BYTES(16), .ROT(0)) dut_a (
      .clk(clk), .reset(reset), .sbox_out(sbox_out), .sbox_valid(sbox_valid),
      .tvalid(tvalid), .dec(dec), .state_in(state_in), .round_key(round_key),
      .state_out(so_a), .valid(v_a), .sbox_ready(rdy_a), .sbox_bad(bad_a), .drop(drp_a));

   f_round_param #(.BYTES(16), .ROT(ROTB)) dut_b (
      .clk(clk), .reset(reset), .sbox_out(sbox_out), .sbox_valid(sbox_valid),
      .tvalid(tvalid), .dec(dec), .state_in(state_in), .round_key(round_key),
      .state_out(so_b), .valid(v_b), .sbox_ready(rdy_b), .sbox_bad(bad_b), .drop(drp_b));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_byte(input logic [7:0] b);
      sbox_out   = b;
      sbox_valid = 1'b1;
      mS[m_idx]  = b;
      mSi[b]     = m_idx[7:0];
      m_idx      = (m_idx + 1) % 256;
      step();
      sbox_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] model(input logic d, input logic [W-1:0] s,
                                          input logic [W-1:0] k, input int rot);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (!d) r[8*((i+rot)%16) +: 8] = mS[s[8*i +: 8] ^ k[8*i +: 8]];
         else    r[8*i +: 8] = mSi[s[8*((i+rot)%16) +: 8]] ^ k[8*i +: 8];
      end
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      checks++;
      if (v_a !== 1'b0 || v_b !== 1'b0 || drp_a !== 1'b0 || drp_b !== 1'b0) begin
         errors++; $display("FAIL reset_valid_drop: valid=%b/%b drop=%b/%b want 0", v_a, v_b, drp_a, drp_b);
      end
      checks++;
      if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || bad_a !== 1'b0 || bad_b !== 1'b0) begin
         errors++; $display("FAIL reset_sbox_flags: ready=%b/%b bad=%b/%b want 0", rdy_a, rdy_b, bad_a, bad_b);
      end
      checks++;
      if (so_a !== '0 || so_b !== '0) begin
         errors++; $display("FAIL reset_state_out: got %h / %h want 0", so_a, so_b);
      end
      reset = 1'b0;
      m_idx = 0;
      step();
   endtask

   task automatic test_drop();
      state_in = 128'h1234; round_key = '0; dec = 1'b0; tvalid = 1'b1;
      step();
      tvalid = 1'b0;
      checks++;
      if (drp_a !== 1'b1 || drp_b !== 1'b1) begin
         errors++; $display("FAIL drop_pulse: got %b/%b want 1", drp_a, drp_b);
      end
      step();
      checks++;
      if (drp_a !== 1'b0 || drp_b !== 1'b0) begin
         errors++; $display("FAIL drop_one_cycle: got %b/%b want 0", drp_a, drp_b);
      end
      step();
      checks++;
      if (v_a !== 1'b0 || v_b !== 1'b0) begin
         errors++; $display("FAIL drop_no_valid: got %b/%b want 0", v_a, v_b);
      end
   endtask

   task automatic test_bad_load();
      load_byte(8'h07);
      checks++;
      if (bad_a !== 1'b0 || bad_b !== 1'b0) begin
         errors++; $display("FAIL bad_first_write: got %b/%b want 0", bad_a, bad_b);
      end
      load_byte(8'h07);
      checks++;
      if (bad_a !== 1'b1 || bad_b !== 1'b1) begin
         errors++; $display("FAIL bad_duplicate: got %b/%b want 1", bad_a, bad_b);
      end
      for (int k = 2; k < 256; k++) load_byte(8'(k));
      checks++;
      if (rdy_a !== 1'b1 || bad_a !== 1'b1 || rdy_b !== 1'b1 || bad_b !== 1'b1) begin
         errors++; $display("FAIL bad_after_full: ready=%b/%b bad=%b/%b want 1,1", rdy_a, rdy_b, bad_a, bad_b);
      end
   endtask

   task automatic test_load_reverse();
      load_byte(8'd255);
      checks++;
      if (rdy_a !== 1'b0 || bad_a !== 1'b0 || rdy_b !== 1'b0 || bad_b !== 1'b0) begin
         errors++; $display("FAIL reload_clears: ready=%b/%b bad=%b/%b want 0,0", rdy_a, rdy_b, bad_a, bad_b);
      end
      for (int k = 1; k < 255; k++) load_byte(8'(255 - k));
      checks++;
      if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
         errors++; $display("FAIL ready_after_255: got %b/%b want 0", rdy_a, rdy_b);
      end
      load_byte(8'd0);
      checks++;
      if (rdy_a !== 1'b1 || bad_a !== 1'b0 || rdy_b !== 1'b1 || bad_b !== 1'b0) begin
         errors++; $display("FAIL ready_after_256: ready=%b/%b bad=%b/%b want 1,0", rdy_a, rdy_b, bad_a, bad_b);
      end
   endtask

   task automatic test_vectors();
      logic [W-1:0] eb, db;
      eb = model(1'b0, '0, KVEC, ROTB);
      state_in = '0; round_key = KVEC; dec = 1'b0; tvalid = 1'b1;
      step();
      tvalid = 1'b0;
      step();
      checks++;
      if (v_a !== 1'b0 || v_b !== 1'b0) begin
         errors++; $display("FAIL latency_early: valid=%b/%b want 0", v_a, v_b);
      end
      step();
      checks++;
      if (v_a !== 1'b1 || so_a !== 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF) begin
         errors++; $display("FAIL enc_vector_rot0: valid=%b got %h want F0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF", v_a, so_a);
      end
      checks++;
      if (v_b !== 1'b1 || so_b !== eb) begin
         errors++; $display("FAIL enc_vector_rot5: valid=%b got %h want %h", v_b, so_b, eb);
      end
      db = model(1'b1, '1, KVEC, ROTB);
      state_in = '1; round_key = KVEC; dec = 1'b1; tvalid = 1'b1;
      step();
      tvalid = 1'b0;
      step(); step();
      checks++;
      if (v_a !== 1'b1 || so_a !== KVEC) begin
         errors++; $display("FAIL dec_vector_rot0: valid=%b got %h want %h", v_a, so_a, KVEC);
      end
      checks++;
      if (v_b !== 1'b1 || so_b !== db) begin
         errors++; $display("FAIL dec_vector_rot5: valid=%b got %h want %h", v_b, so_b, db);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] s [3], k [3], ea [3], eb [3];
      logic         d [3];
      for (int i = 0; i < 3; i++) begin
         s[i] = {$urandom, $urandom, $urandom, $urandom};
         k[i] = {$urandom, $urandom, $urandom, $urandom};
         d[i] = i[0];
         ea[i] = model(d[i], s[i], k[i], 0);
         eb[i] = model(d[i], s[i], k[i], ROTB);
      end
      for (int c = 0; c < 5; c++) begin
         if (c < 3) begin
            state_in = s[c]; round_key = k[c]; dec = d[c]; tvalid = 1'b1;
         end else tvalid = 1'b0;
         step();
         checks++;
         if (c >= 2) begin
            if (v_a !== 1'b1 || v_b !== 1'b1 || so_a !== ea[c-2] || so_b !== eb[c-2]) begin
               errors++; $display("FAIL b2b_block%0d: valid=%b/%b got %h / %h want %h / %h",
                                  c-2, v_a, v_b, so_a, so_b, ea[c-2], eb[c-2]);
            end
         end else if (v_a !== 1'b0 || v_b !== 1'b0) begin
            errors++; $display("FAIL b2b_early%0d: valid=%b/%b want 0", c, v_a, v_b);
         end
      end
      last_a = ea[2]; last_b = eb[2];
   endtask

   task automatic test_hold();
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (v_a !== 1'b0 || so_a !== last_a || v_b !== 1'b0 || so_b !== last_b) begin
            errors++; $display("FAIL hold_cycle%0d: valid=%b/%b got %h / %h want %h / %h",
                               c, v_a, v_b, so_a, so_b, last_a, last_b);
         end
      end
   endtask

   task automatic test_load_overlap();
      logic [W-1:0] p, k, ea, eb;
      p = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      ea = model(1'b0, p, k, 0);
      eb = model(1'b0, p, k, ROTB);
      state_in = p; round_key = k; dec = 1'b0; tvalid = 1'b1;
      load_byte(mS[0]);
      checks++;
      if (rdy_a !== 1'b0 || drp_a !== 1'b0 || rdy_b !== 1'b0 || drp_b !== 1'b0) begin
         errors++; $display("FAIL overlap_accept: ready=%b/%b drop=%b/%b want 0,0", rdy_a, rdy_b, drp_a, drp_b);
      end
      load_byte(mS[1]);
      tvalid = 1'b0;
      checks++;
      if (drp_a !== 1'b1 || drp_b !== 1'b1 || v_a !== 1'b0) begin
         errors++; $display("FAIL overlap_drop_midload: drop=%b/%b valid=%b want 1,1,0", drp_a, drp_b, v_a);
      end
      load_byte(mS[2]);
      checks++;
      if (v_a !== 1'b1 || v_b !== 1'b1 || so_a !== ea || so_b !== eb) begin
         errors++; $display("FAIL overlap_block: valid=%b/%b got %h / %h want %h / %h", v_a, v_b, so_a, so_b, ea, eb);
      end
      for (int i = 3; i < 256; i++) load_byte(mS[i]);
      checks++;
      if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || bad_a !== 1'b0) begin
         errors++; $display("FAIL overlap_reload_done: ready=%b/%b bad=%b want 1,1,0", rdy_a, rdy_b, bad_a);
      end
   endtask

   task automatic test_random();
      localparam int N = 24;
      logic [7:0]   perm [256];
      logic [W-1:0] s [N], k [N], ea [N], eb [N];
      logic         d [N];
      logic [W-1:0] p, key, c;
      logic [7:0]   t;
      int           j;
      for (int i = 0; i < 256; i++) perm[i] = 8'(i);
      for (int i = 255; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 256; i++) load_byte(perm[i]);
      for (int i = 0; i < N; i++) begin
         s[i] = {$urandom, $urandom, $urandom, $urandom};
         k[i] = {$urandom, $urandom, $urandom, $urandom};
         d[i] = 1'($urandom_range(1, 0));
         ea[i] = model(d[i], s[i], k[i], 0);
         eb[i] = model(d[i], s[i], k[i], ROTB);
      end
      for (int cy = 0; cy < N + 2; cy++) begin
         if (cy < N) begin
            state_in = s[cy]; round_key = k[cy]; dec = d[cy]; tvalid = 1'b1;
         end else tvalid = 1'b0;
         step();
         if (cy >= 2) begin
            checks++;
            if (v_a !== 1'b1 || v_b !== 1'b1 || so_a !== ea[cy-2] || so_b !== eb[cy-2]) begin
               errors++; $display("FAIL random_block%0d: valid=%b/%b got %h / %h want %h / %h",
                                  cy-2, v_a, v_b, so_a, so_b, ea[cy-2], eb[cy-2]);
            end
         end
      end
      for (int inst = 0; inst < 2; inst++) begin
         p   = {$urandom, $urandom, $urandom, $urandom};
         key = {$urandom, $urandom, $urandom, $urandom};
         state_in = p; round_key = key; dec = 1'b0; tvalid = 1'b1;
         step();
         tvalid = 1'b0;
         step(); step();
         c = (inst == 0) ? so_a : so_b;
         state_in = c; dec = 1'b1; tvalid = 1'b1;
         step();
         tvalid = 1'b0;
         step(); step();
         checks++;
         if (inst == 0 && so_a !== p) begin
            errors++; $display("FAIL roundtrip_rot0: got %h want %h", so_a, p);
         end else if (inst == 1 && so_b !== p) begin
            errors++; $display("FAIL roundtrip_rot5: got %h want %h", so_b, p);
         end
      end
   endtask

   task automatic test_reset_inflight();
      state_in = {$urandom, $urandom, $urandom, $urandom}; round_key = '0; dec = 1'b0; tvalid = 1'b1;
      step();
      dec = 1'b1;
      step();
      tvalid = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if (v_a !== 1'b0 || v_b !== 1'b0 || so_a !== '0 || so_b !== '0 || rdy_a !== 1'b0 || rdy_b !== 1'b0
          || bad_a !== 1'b0 || drp_a !== 1'b0) begin
         errors++; $display("FAIL reset_inflight_immediate: valid=%b/%b out=%h ready=%b bad=%b drop=%b want all 0",
                            v_a, v_b, so_a, rdy_a, bad_a, drp_a);
      end
      step(); step();
      reset = 1'b0;
      m_idx = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (v_a !== 1'b0 || v_b !== 1'b0) begin
            errors++; $display("FAIL reset_inflight_valid%0d: got %b/%b want 0", c, v_a, v_b);
         end
      end
   endtask

   initial begin
      reset = 1'b1; sbox_out = '0; sbox_valid = 1'b0; tvalid = 1'b0; dec = 1'b0;
      state_in = '0; round_key = '0;
      test_reset();
      test_drop();
      test_bad_load();
      test_load_reverse();
      test_vectors();
      test_back_to_back();
      test_hold();
      test_load_overlap();
      test_random();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
